// File: rtl/serial_full_subtractor.sv
// rtl/serial_full_subtractor.sv - bit-serial LSB-first subtractor D = A - B with registered borrow
// Optional feature: define SERIAL_SUB_OVF_EN to add the two's-complement overflow output.
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    input  logic a_bit,
    input  logic b_bit,
    output logic diff_valid,
    output logic diff_bit,
    output logic busy,
    output logic done,
    output logic borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic overflow
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t        state;
    logic          br;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          diff_c;
    logic          br_c;
    logic          last_beat;

    assign in_ready  = (state == RUN);
    assign accept    = in_valid & in_ready;
    assign diff_c    = a_bit ^ b_bit ^ br;
    assign br_c      = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    assign last_beat = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            br         <= 1'b0;
            cnt        <= '0;
            diff_valid <= 1'b0;
            diff_bit   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            overflow   <= 1'b0;
`endif
        end else begin
            diff_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        br         <= 1'b0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        overflow   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
                        diff_bit   <= diff_c;
                        diff_valid <= 1'b1;
                        br         <= br_c;
                        if (last_beat) begin
                            // terminal beat: counter stops here, result flags latch with the last bit
                            state      <= DONE_S;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            borrow_out <= br_c;
`ifdef SERIAL_SUB_OVF_EN
                            overflow   <= (a_bit ^ b_bit) & (a_bit ^ diff_c);
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE_S: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// tb/tb_serial_full_subtractor.sv - randomized and directed bench for serial_full_subtractor (WIDTH=4)
module tb_serial_full_subtractor;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n, start, in_valid, in_ready, a_bit, b_bit;
    logic diff_valid, diff_bit, busy, done, borrow_out;
    logic overflow;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] got_bits;
    int npulse;
    int ndone;

    serial_full_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .diff_valid (diff_valid),
        .diff_bit   (diff_bit),
        .busy       (busy),
        .done       (done),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign overflow = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock; outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        if (diff_valid === 1'b1) begin
            if (npulse < W) got_bits[npulse] = diff_bit;
            npulse++;
        end
        if (done === 1'b1) ndone++;
    endtask

    // reference: {overflow, borrow, diff} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int d, sa, sb, sd;
        logic [W-1:0] dm;
        logic bo, ov;
        d  = int'(a) - int'(b);
        bo = (d < 0);
        dm = W'(d);
        sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
        sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
        sd = sa - sb;
        ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        return {ov, bo, dm};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall, input bit abuse);
        logic [W+1:0] m;
        m = model(a, b);
        got_bits = '0;
        npulse = 0;
        ndone = 0;
        start = 1'b1;
        step();
        start = abuse;
        check("busy_run", busy, 1);
        check("in_ready_run", in_ready, 1);
        for (int i = 0; i < W; i++) begin
            for (int s = 0; s < stall; s++) begin
                in_valid = 1'b0;
                a_bit = 1'($urandom);
                b_bit = 1'($urandom);
                step();
                check("busy_stall", busy, 1);
            end
            in_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            step();
        end
        in_valid = 1'b0;
        check("done_with_last", {done, diff_valid}, 2'b11);
        check("borrow_out", borrow_out, m[W]);
`ifdef SERIAL_SUB_OVF_EN
        check("overflow", overflow, m[W+1]);
`endif
        step();
        start = 1'b0;
        check("done_gone", {done, busy}, 2'b00);
        check("diff_value", got_bits, m[W-1:0]);
        check("pulse_count", npulse, W);
        check("done_count", ndone, 1);
        check("borrow_held", borrow_out, m[W]);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        a_bit = 1'b0;
        b_bit = 1'b0;
        npulse = 0;
        ndone = 0;
        got_bits = '0;
        step();
        step();
        check("reset_outputs", {in_ready, diff_valid, diff_bit, busy, done, borrow_out, overflow}, 0);
        rst_n = 1'b1;
        step();

        run_op(4'b0101, 4'b0011, 0, 1'b0);
        check("5m3_diff", got_bits, 4'b0010);
        run_op(4'b0011, 4'b0101, 0, 1'b0);
        check("3m5_diff", got_bits, 4'b1110);
        check("3m5_borrow", borrow_out, 1);

        // abort mid-operation after two beats
        start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        in_valid = 1'b1;
        a_bit = 1'b1;
        b_bit = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("async_reset", {in_ready, diff_valid, diff_bit, busy, done, borrow_out, overflow}, 0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("no_done_after_abort", ndone, 0);
        check("idle_after_abort", {busy, in_ready}, 2'b00);

        run_op(4'b0101, 4'b0011, 2, 1'b0);

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        a_bit = 1'b1;
        b_bit = 1'b1;
        npulse = 0;
        step();
        step();
        in_valid = 1'b0;
        check("idle_in_valid_ignored", {npulse[0], busy, in_ready}, 3'b000);
        run_op(4'b0101, 4'b0011, 1, 1'b1);

        run_op(4'b0111, 4'b1111, 0, 1'b0);
        check("7m_neg1_diff", got_bits, 4'b1000);
        run_op(4'b1000, 4'b0001, 1, 1'b0);
        check("8m1_diff", got_bits, 4'b0111);
        run_op(4'b1111, 4'b1111, 0, 1'b0);
        run_op(4'b0000, 4'b1111, 0, 1'b0);

        for (int n = 0; n < 20; n++)
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
